// File: rtl/ddfs_phase_fold_if.sv
// Bus bundle for ddfs_phase_fold: tuning-word handshake, control strobes and folded phase outputs.
interface ddfs_phase_fold_if #(
  parameter int N = 18,
  parameter int L = 6
);
  logic             en;
  logic             sync_clr;
  logic [N-1:0]     ftw;
  logic             ftw_valid;
  logic             ftw_ready;
  logic [N-1:0]     phase_off;
  logic             lm_in;
  logic [L-1:0]     phi_lut;
  logic             LM;
  logic [N-4-L:0]   phi_res;
  logic [2:0]       oct;
  logic             out_valid;

  modport master (
    output en, sync_clr, ftw, ftw_valid, phase_off, lm_in,
    input  ftw_ready, phi_lut, LM, phi_res, oct, out_valid
  );

  modport slave (
    input  en, sync_clr, ftw, ftw_valid, phase_off, lm_in,
    output ftw_ready, phi_lut, LM, phi_res, oct, out_valid
  );
endinterface

// File: rtl/ddfs_phase_fold.sv
// DDFS phase accumulator with octant folding into LUT address/residual.
// Optional LFSR phase dither is enabled by defining DDFS_DITHER_EN.
module ddfs_phase_fold #(
  parameter int N = 18,
  parameter int L = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  ddfs_phase_fold_if.slave  bus
);

  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   p2_q, p2_d;
  logic [N-1:0]   ftw_act_q, ftw_act_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic           pending_q, pending_d;
  logic           v2_q, v2_d;
  logic           lm2_q, lm2_d;
  logic [L-1:0]   phi_lut_q, phi_lut_d;
  logic [N-4-L:0] phi_res_q, phi_res_d;
  logic [2:0]     oct_q, oct_d;
  logic           lm_q, lm_d;
  logic           out_valid_q, out_valid_d;
  logic [N-4:0]   fold;
  logic [N-1:0]   dith;

`ifdef DDFS_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Fibonacci form of taps 16,14,13,11
  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.en) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign dith = {{(N-4){1'b0}}, lfsr_q[3:0]};
`else
  assign dith = '0;
`endif

  always_comb begin
    acc_d     = acc_q;
    p2_d      = p2_q;
    ftw_act_d = ftw_act_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    v2_d      = 1'b0;
    lm2_d     = lm2_q;

    if (bus.ftw_valid && !pending_q) begin
      shadow_d  = bus.ftw;
      pending_d = 1'b1;
    end

    // The step taken in the apply cycle still uses the previous ftw_act
    if (bus.en) begin
      acc_d = acc_q + ftw_act_q;
      p2_d  = acc_q + bus.phase_off + dith;
      v2_d  = 1'b1;
      lm2_d = bus.lm_in;
      if (pending_q) begin
        ftw_act_d = shadow_q;
        pending_d = 1'b0;
      end
    end

    if (bus.sync_clr) begin
      acc_d = '0;
      v2_d  = 1'b0;
    end
  end

  always_comb begin
    fold        = p2_q[N-3] ? ~p2_q[N-4:0] : p2_q[N-4:0];
    oct_d       = p2_q[N-1:N-3];
    phi_lut_d   = fold[N-4 -: L];
    phi_res_d   = fold[N-4-L:0];
    lm_d        = lm2_q;
    out_valid_d = v2_q && !bus.sync_clr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      p2_q        <= '0;
      ftw_act_q   <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      v2_q        <= 1'b0;
      lm2_q       <= 1'b0;
      phi_lut_q   <= '0;
      phi_res_q   <= '0;
      oct_q       <= '0;
      lm_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      p2_q        <= p2_d;
      ftw_act_q   <= ftw_act_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      v2_q        <= v2_d;
      lm2_q       <= lm2_d;
      phi_lut_q   <= phi_lut_d;
      phi_res_q   <= phi_res_d;
      oct_q       <= oct_d;
      lm_q        <= lm_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.ftw_ready = ~pending_q;
  assign bus.phi_lut   = phi_lut_q;
  assign bus.phi_res   = phi_res_q;
  assign bus.oct       = oct_q;
  assign bus.LM        = lm_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_ddfs_phase_fold.sv
// Scoreboard bench for ddfs_phase_fold: directed fold/handshake/clear/reset cases plus random stream.
module tb_ddfs_phase_fold;
  localparam int N = 18;
  localparam int L = 6;
  localparam int R = N - 3 - L;

  typedef struct {
    logic [2:0]   oct;
    logic [L-1:0] lut;
    logic [R-1:0] res;
    logic         lm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ddfs_phase_fold_if #(.N(N), .L(L)) bus ();
  ddfs_phase_fold #(.N(N), .L(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  logic [N-1:0] m_acc = '0, m_act = '0, m_shadow = '0;
  logic         m_pend = 1'b0, m_v2 = 1'b0, m_ov = 1'b0;
  logic [15:0]  m_lfsr = 16'hACE1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t predict(input logic [N-1:0] p, input logic lm);
    exp_t e;
    int unsigned o, f;
    o = int'(p) / (1 << (N-3));
    f = int'(p) % (1 << (N-3));
    if (o % 2 == 1) f = (1 << (N-3)) - 1 - f;
    e.oct = o[2:0];
    e.lut = L'(f >> R);
    e.res = R'(f % (1 << R));
    e.lm  = lm;
    return e;
  endfunction

  task automatic cyc(input logic en, input logic clr, input logic fv, input logic [N-1:0] ftw,
                     input logic [N-1:0] off, input logic lm, input logic rst);
    exp_t cur;
    logic [N-1:0] dith, n_acc, n_act, n_sh, p;
    logic n_pend;
    bus.en = en; bus.sync_clr = clr; bus.ftw_valid = fv; bus.ftw = ftw;
    bus.phase_off = off; bus.lm_in = lm; rst_n = ~rst;
    #1;
    if (!rst) check_eq("ftw_ready", {31'b0, bus.ftw_ready}, {31'b0, !m_pend});
`ifdef DDFS_DITHER_EN
    dith = {{(N-4){1'b0}}, m_lfsr[3:0]};
`else
    dith = '0;
`endif
    if (rst) begin
      m_acc = '0; m_act = '0; m_shadow = '0; m_pend = 1'b0; m_v2 = 1'b0; m_ov = 1'b0;
      m_lfsr = 16'hACE1;
      sb.delete();
    end else begin
      m_ov = 1'b0;
      if (m_v2 && sb.size() > 0) begin
        cur  = sb.pop_front();
        m_ov = !clr;
      end
      m_v2 = en && !clr;
      p = m_acc + off + dith;
      if (en && !clr) sb.push_back(predict(p, lm));
      n_acc = clr ? '0 : (en ? m_acc + m_act : m_acc);
      n_act = m_act; n_sh = m_shadow; n_pend = m_pend;
      if (fv && !m_pend) begin n_sh = ftw; n_pend = 1'b1; end
      if (en && m_pend) begin n_act = m_shadow; n_pend = 1'b0; end
      m_acc = n_acc; m_act = n_act; m_shadow = n_sh; m_pend = n_pend;
      if (en) m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
    if (m_ov) begin
      check_eq("oct", {29'b0, bus.oct}, {29'b0, cur.oct});
      check_eq("phi_lut", 32'(bus.phi_lut), 32'(cur.lut));
      check_eq("phi_res", 32'(bus.phi_res), 32'(cur.res));
      check_eq("LM", {31'b0, bus.LM}, {31'b0, cur.lm});
    end
  endtask

  initial begin
    cyc(0, 0, 0, '0, '0, 0, 1);
    cyc(0, 0, 0, '0, '0, 0, 1);
    check_eq("rst_phi_lut", 32'(bus.phi_lut), 0);
    check_eq("rst_oct", 32'(bus.oct), 0);

    // Fold cases with acc held at zero so p2 equals phase_off
    cyc(1, 0, 0, '0, 18'h01200, 0, 0);
    cyc(0, 0, 0, '0, 18'h01200, 0, 0);
`ifndef DDFS_DITHER_EN
    check_eq("even_oct", 32'(bus.oct), 0);
    check_eq("even_lut", 32'(bus.phi_lut), 9);
    check_eq("even_res", 32'(bus.phi_res), 0);
`endif
    cyc(1, 0, 0, '0, 18'h0A000, 1, 0);
    cyc(0, 0, 0, '0, 18'h0A000, 1, 0);
`ifndef DDFS_DITHER_EN
    check_eq("odd_oct", 32'(bus.oct), 1);
    check_eq("odd_lut", 32'(bus.phi_lut), 32'h2F);
    check_eq("odd_res", 32'(bus.phi_res), 32'h1FF);
    check_eq("odd_lm", {31'b0, bus.LM}, 1);
`endif

    // Handshake and accumulator wrap
    cyc(0, 0, 0, '0, '0, 0, 1);
    cyc(1, 0, 1, 18'h01000, '0, 0, 0);
    check_eq("ready_low", {31'b0, bus.ftw_ready}, 0);
    for (int i = 0; i < 70; i++) cyc(1, 0, 0, '0, '0, 0, 0);

    // Hold for three cycles then resume
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, '0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, '0, '0, 1, 0);

    // Clear pulse, then first valid output sits at phase zero
    cyc(1, 1, 0, '0, '0, 0, 0);
    cyc(1, 0, 0, '0, '0, 0, 0);
    cyc(1, 0, 0, '0, '0, 0, 0);
`ifndef DDFS_DITHER_EN
    check_eq("clr_valid", {31'b0, bus.out_valid}, 1);
    check_eq("clr_lut", 32'(bus.phi_lut), 0);
    check_eq("clr_oct", 32'(bus.oct), 0);
`endif

    // Clear together with an ftw accept
    cyc(1, 1, 1, 18'h00800, '0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, '0, '0, 0, 0);

    // Mid-stream reset
    cyc(1, 0, 0, '0, 18'h12345, 1, 1);
    check_eq("mrst_lut", 32'(bus.phi_lut), 0);
    check_eq("mrst_res", 32'(bus.phi_res), 0);
    check_eq("mrst_oct", 32'(bus.oct), 0);
    check_eq("mrst_lm", {31'b0, bus.LM}, 0);
    check_eq("mrst_ready", {31'b0, bus.ftw_ready}, 1);

    for (int i = 0; i < 1000; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 3) == 0,
          N'($urandom), N'($urandom), 1'($urandom), ($urandom % 128) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
